// File: rtl/traffic_sensor_conditioner.sv
// Two-lane vehicle detector conditioner: sync, debounce/hold FSM and a saturating
// vehicle counter per lane, producing clean presence t[1:0] for the light FSM.
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE = 4,
  parameter int HOLD     = 8,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    sensor_raw,
  input  logic          tick,
  input  logic          clr_count,
  output logic [1:0]    t,
  output logic [1:0]    car_pulse,
  output logic [CW-1:0] count_a,
  output logic [CW-1:0] count_b
);

  localparam int MAXDH = (DEBOUNCE > HOLD) ? DEBOUNCE : HOLD;
  localparam int CNTW  = (MAXDH > 1) ? $clog2(MAXDH) : 1;
  localparam logic [CNTW-1:0] DB_LAST   = CNTW'(DEBOUNCE - 1);
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, ARM, PRESENT, RELEASE} state_e;

  logic [1:0][CW-1:0] count_q;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic            s1_q, s2_q;
    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            t_q, pulse_q, pulse_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (s2_q) begin
            state_d = ARM;
            cnt_d   = '0;
          end
        end
        ARM: begin
          if (!s2_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (tick && cnt_q == DB_LAST) begin
            state_d = PRESENT;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESENT: begin
          if (!s2_q) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end
        RELEASE: begin
          // Re-detection inside the hold window is the same vehicle: no pulse.
          if (s2_q) begin
            state_d = PRESENT;
            cnt_d   = '0;
          end else if (tick && cnt_q == HOLD_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        state_q <= IDLE;
        cnt_q   <= '0;
        t_q     <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        s1_q    <= sensor_raw[g];
        s2_q    <= s1_q;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        t_q     <= (state_d == PRESENT) || (state_d == RELEASE);
        pulse_q <= pulse_d;
      end
    end

    // Clear wins over a coincident pulse; the count saturates at all-ones.
    always_ff @(posedge clk) begin
      if (reset || clr_count) begin
        count_q[g] <= '0;
      end else if (pulse_q && count_q[g] != {CW{1'b1}}) begin
        count_q[g] <= count_q[g] + 1'b1;
      end
    end

    assign t[g]         = t_q;
    assign car_pulse[g] = pulse_q;
  end

  assign count_a = count_q[0];
  assign count_b = count_q[1];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner: per-cycle compare against a
// run-length presence model, plus literal checkpoints from the test plan.
module tb_traffic_sensor_conditioner;
  localparam int DEBOUNCE = 4;
  localparam int HOLD     = 8;
  localparam int CW       = 2;
  localparam int MAXC     = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    sensor_raw = 2'b00;
  logic          tick = 1'b1;
  logic          clr_count = 1'b0;
  logic [1:0]    t, car_pulse;
  logic [CW-1:0] count_a, count_b;

  int errors = 0;
  int checks = 0;

  traffic_sensor_conditioner #(.DEBOUNCE(DEBOUNCE), .HOLD(HOLD), .CW(CW)) dut (
    .clk(clk), .reset(reset), .sensor_raw(sensor_raw), .tick(tick),
    .clr_count(clr_count), .t(t), .car_pulse(car_pulse),
    .count_a(count_a), .count_b(count_b)
  );

  always #5 clk = ~clk;

  // Model: a lane is present or not; while absent it counts tick edges of an
  // unbroken high run (first high edge only opens the run), while present it
  // counts tick edges of an unbroken low run the same way.
  logic [1:0] m_d1, m_d2, m_hirun, m_lorun, exp_t, exp_pulse;
  int         m_hi[2], m_lo[2], exp_cnt[2];
  bit         model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_d1 <= '0; m_d2 <= '0; m_hirun <= '0; m_lorun <= '0;
      exp_t <= '0; exp_pulse <= '0;
      for (int i = 0; i < 2; i++) begin
        m_hi[i] <= 0; m_lo[i] <= 0; exp_cnt[i] <= 0;
      end
      model_ok <= 1'b1;
    end else begin
      m_d1 <= sensor_raw;
      m_d2 <= m_d1;
      for (int i = 0; i < 2; i++) begin
        logic np, pl;
        np = exp_t[i];
        pl = 1'b0;
        if (!exp_t[i]) begin
          if (!m_d2[i]) begin
            m_hirun[i] <= 1'b0; m_hi[i] <= 0;
          end else if (!m_hirun[i]) begin
            m_hirun[i] <= 1'b1; m_hi[i] <= 0;
          end else if (tick) begin
            if (m_hi[i] + 1 == DEBOUNCE) begin
              np = 1'b1; pl = 1'b1; m_hirun[i] <= 1'b0; m_lorun[i] <= 1'b0;
            end else m_hi[i] <= m_hi[i] + 1;
          end
        end else begin
          if (m_d2[i]) begin
            m_lorun[i] <= 1'b0; m_lo[i] <= 0;
          end else if (!m_lorun[i]) begin
            m_lorun[i] <= 1'b1; m_lo[i] <= 0;
          end else if (tick) begin
            if (m_lo[i] + 1 == HOLD) begin
              np = 1'b0; m_lorun[i] <= 1'b0; m_hirun[i] <= 1'b0; m_hi[i] <= 0;
            end else m_lo[i] <= m_lo[i] + 1;
          end
        end
        exp_t[i]     <= np;
        exp_pulse[i] <= pl;
        if (clr_count) exp_cnt[i] <= 0;
        else if (exp_pulse[i]) exp_cnt[i] <= (exp_cnt[i] < MAXC) ? exp_cnt[i] + 1 : MAXC;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if (t !== exp_t || car_pulse !== exp_pulse ||
          count_a !== CW'(exp_cnt[0]) || count_b !== CW'(exp_cnt[1])) begin
        errors++;
        $display("FAIL model t=%b/%b pulse=%b/%b cnt_a=%0d/%0d cnt_b=%0d/%0d (got/required) at %0t",
                 t, exp_t, car_pulse, exp_pulse, count_a, exp_cnt[0], count_b, exp_cnt[1], $time);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d at %0t", name, got, req, $time);
    end
  endtask

  task automatic vehicle_b(input bool_last);
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    chk("reset_t", t, 0);
    chk("reset_cnt", {count_a, count_b}, 0);

    // clean assert on lane A: edge E0 is the first edge sampling raw high
    sensor_raw = 2'b01;
    step(6);
    chk("assert_early_t", t, 0);
    step(1);
    chk("assert_t", t, 1);
    chk("assert_pulse", car_pulse, 1);
    step(1);
    chk("assert_pulse_end", car_pulse, 0);
    chk("assert_count_a", count_a, 1);

    // hold bridging: short drop is absorbed
    sensor_raw = 2'b00;
    step(5);
    sensor_raw = 2'b01;
    step(12);
    chk("bridge_t", t[0], 1);
    chk("bridge_count_a", count_a, 1);

    // long drop: t falls after HOLD+2 edges
    sensor_raw = 2'b00;
    step(10);
    chk("release_late_t", t[0], 1);
    step(1);
    chk("release_t", t[0], 0);
    step(2);

    // glitch on lane B shorter than the debounce window
    sensor_raw = 2'b10;
    step(4);
    sensor_raw = 2'b00;
    step(8);
    chk("glitch_t", t[1], 0);
    chk("glitch_count_b", count_b, 0);

    // tick one cycle in four: ARM at edge 2, ticks at edges 3,7,11,15
    for (int c = 0; c < 18; c++) begin
      tick = (c % 4 == 3);
      if (c == 0) sensor_raw = 2'b01;
      step(1);
      if (c == 14) chk("tick_early_t", t[0], 0);
      if (c == 15) begin
        chk("tick_t", t[0], 1);
        chk("tick_pulse", car_pulse[0], 1);
      end
    end
    tick = 1'b1;
    sensor_raw = 2'b00;
    step(12);
    chk("tick_count_a", count_a, 2);

    // saturation on lane B with CW=2, clear coincident with the fifth pulse
    for (int v = 1; v <= 5; v++) begin
      sensor_raw = 2'b10;
      step(7);
      chk("sat_pulse", car_pulse[1], 1);
      if (v == 5) clr_count = 1'b1;
      step(1);
      clr_count = 1'b0;
      if (v == 3) chk("sat_count3", count_b, 3);
      if (v == 4) chk("sat_count4", count_b, 3);
      if (v == 5) chk("clr_count_b", count_b, 0);
      sensor_raw = 2'b00;
      step(12);
    end
    chk("clr_count_a", count_a, 0);

    // both lanes rise together; reset while both are arming
    sensor_raw = 2'b11;
    step(4);
    reset = 1'b1;
    step(1);
    chk("midreset_t", t, 0);
    chk("midreset_pulse", car_pulse, 0);
    chk("midreset_cnt", {count_a, count_b}, 0);
    reset = 1'b0;
    step(6);
    chk("redetect_early_t", t, 0);
    step(1);
    chk("redetect_t", t, 3);
    chk("redetect_pulse", car_pulse, 3);
    step(2);
    chk("redetect_cnt", {count_a, count_b}, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
